// File: rtl/filtro_pkg.sv
// Shared constants and FSM state type for the filter MAC path.
package filtro_pkg;

    localparam int unsigned N = 25;
    localparam int unsigned F = 16;

    localparam logic [N-1:0] SAT_POS = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] SAT_NEG = {1'b1, {(N-2){1'b0}}, 1'b1};
    localparam logic [N-1:0] MIN_VAL = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DONE
    } state_t;

endpackage

// File: rtl/mult_sat.sv
// Combinational fixed-point multiply with symmetric saturation to N bits.
module mult_sat
    import filtro_pkg::*;
(
    input  logic [N-1:0] coef,
    input  logic [N-1:0] x,
    output logic [N-1:0] prod,
    output logic         sat
);

    localparam int unsigned PW = 2 * N;
    localparam logic signed [PW-1:0] LIM = PW'(SAT_POS);

    logic signed [PW-1:0] full;
    logic signed [PW-1:0] shifted;

    // Arithmetic shift truncates toward -inf; clamp keeps -2^(N-1) out of range.
    always_comb begin
        full    = $signed({{N{coef[N-1]}}, coef}) * $signed({{N{x[N-1]}}, x});
        shifted = full >>> F;
        prod    = shifted[N-1:0];
        sat     = 1'b0;
        if (shifted > LIM) begin
            prod = SAT_POS;
            sat  = 1'b1;
        end else if (shifted < -LIM) begin
            prod = SAT_NEG;
            sat  = 1'b1;
        end
    end

endmodule

// File: rtl/mac_secuencial.sv
// Sequential saturating multiply-accumulate over TAPS coefficient/sample pairs.
// Optional sticky overflow flag port ovf is built when MAC_OVF_FLAG_EN is defined.
module mac_secuencial
    import filtro_pkg::*;
#(
    parameter int unsigned TAPS = 5,
    parameter int unsigned AW   = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [N-1:0]  coef,
    input  logic [N-1:0]  x,
    output logic [AW-1:0] idx,
    output logic          busy,
    output logic          done,
    output logic [N-1:0]  y
`ifdef MAC_OVF_FLAG_EN
    ,
    output logic          ovf
`endif
);

    state_t         state;
    logic [N-1:0]   acc;
    logic [N-1:0]   prod;
    logic           mul_sat;
    logic [N-1:0]   sum;
    logic [N-1:0]   sum_sat;
    logic           add_sat;
    logic           last;

    mult_sat u_mult_sat (
        .coef (coef),
        .x    (x),
        .prod (prod),
        .sat  (mul_sat)
    );

    // Saturating add: same-sign operands with a sign flip (or landing on the
    // asymmetric minimum) clamp to the symmetric limits.
    always_comb begin
        sum     = acc + prod;
        sum_sat = sum;
        add_sat = 1'b0;
        if (!acc[N-1] && !prod[N-1] && sum[N-1]) begin
            sum_sat = SAT_POS;
            add_sat = 1'b1;
        end else if (acc[N-1] && prod[N-1] && (!sum[N-1] || sum == MIN_VAL)) begin
            sum_sat = SAT_NEG;
            add_sat = 1'b1;
        end
    end

    assign last = (idx == AW'(TAPS - 1));

`ifndef MAC_OVF_FLAG_EN
    logic unused_sat;
    assign unused_sat = mul_sat ^ add_sat;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            acc   <= '0;
            idx   <= '0;
            y     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef MAC_OVF_FLAG_EN
            ovf   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state <= ACC;
                        acc   <= '0;
                        idx   <= '0;
                        busy  <= 1'b1;
`ifdef MAC_OVF_FLAG_EN
                        ovf   <= 1'b0;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                ACC: begin
                    acc <= sum_sat;
`ifdef MAC_OVF_FLAG_EN
                    ovf <= ovf | mul_sat | add_sat;
`endif
                    if (last) begin
                        y     <= sum_sat;
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        idx   <= '0;
                    end else begin
                        idx <= idx + AW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
